// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants and helpers for the valid/ready pipeline-stage buffers.
package pipe_stage_buf_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    // Per-stage payload widths, {pc, inst, snpc} = 3 x 32 bits.
    localparam int FD_W = 96;
    localparam int DE_W = 96;

    // A one-entry buffer still needs a 1-bit pointer to stay a legal vector.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready stage register: DEPTH-entry circular buffer, registered
// handshakes on both sides, flush, and an optional zero-storage bypass build.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                DATA_W   = 96,
    parameter int                DEPTH    = 2,
    parameter logic [DATA_W-1:0] RST_DATA = '0,
    parameter int                CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  count
);

`ifdef SINGLE_CYCLE

    assign s_ready = 1'b1;
    assign m_valid = 1'b1;
    assign m_data  = s_data;
    assign count   = '0;

`else

    localparam int                PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    // Handshakes come only from the registered count, so no path crosses the block.
    assign s_ready = (count_q != FULL);
    assign m_valid = (count_q != '0);
    assign m_data  = mem_q[rd_ptr_q];
    assign count   = count_q;

    assign push = s_valid & s_ready & ~flush;
    assign pop  = m_valid & m_ready & ~flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Flush only rewinds the pointers; stale entries are never visible with m_valid=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_DATA;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= s_data;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a DEPTH=2/96-bit instance and a DEPTH=3/16-bit instance.
module tb_pipe_stage_buf;
    import pipe_stage_buf_pkg::*;

    localparam logic [95:0] RST2 = {RESET_PC, 64'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        flush2 = 0, s_valid2 = 0, m_ready2 = 0, s_ready2, m_valid2;
    logic [95:0] s_data2 = '0, m_data2;
    logic [1:0]  count2;

    logic        flush3 = 0, s_valid3 = 0, m_ready3 = 0, s_ready3, m_valid3;
    logic [15:0] s_data3 = '0, m_data3;
    logic [1:0]  count3;

    pipe_stage_buf #(.DATA_W(96), .DEPTH(2), .RST_DATA(RST2)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .count(count2)
    );

    pipe_stage_buf #(.DATA_W(16), .DEPTH(3), .RST_DATA(16'h0)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
        .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3), .count(count3)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [95:0] q2[$];
    logic [15:0] q3[$];

    // Advances the DEPTH=2 reference model by one clock and steps the clock.
    task automatic tick2();
        bit push, pop;
        push = s_valid2 && (q2.size() != 2) && !flush2;
        pop  = m_ready2 && (q2.size() != 0) && !flush2;
        if (flush2) q2.delete();
        else begin
            if (pop)  void'(q2.pop_front());
            if (push) q2.push_back(s_data2);
        end
        @(posedge clk); #1;
    endtask

    task automatic drive2(input bit sv, input logic [95:0] sd, input bit mr, input bit fl);
        s_valid2 = sv; s_data2 = sd; m_ready2 = mr; flush2 = fl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q2.delete(); q3.delete();
        n_cmp++; if (s_ready2 !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got %b exp 1", s_ready2); end
        n_cmp++; if (m_valid2 !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %b exp 0", m_valid2); end
        n_cmp++; if (count2 !== 2'd0)   begin n_err++; $display("FAIL reset_count got %0d exp 0", count2); end
        n_cmp++; if (m_data2 !== RST2)  begin n_err++; $display("FAIL reset_m_data got %h exp %h", m_data2, RST2); end
        n_cmp++; if (s_ready3 !== 1'b1 || m_valid3 !== 1'b0 || count3 !== 2'd0)
            begin n_err++; $display("FAIL reset_d3 got rdy=%b vld=%b cnt=%0d exp 1 0 0", s_ready3, m_valid3, count3); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 16; i++) begin
            drive2(1'b1, 96'(i), 1'b1, 1'b0);
            n_cmp++; if (count2 !== 2'(q2.size()))
                begin n_err++; $display("FAIL stream_count[%0d] got %0d exp %0d", i, count2, q2.size()); end
            if (i > 0) begin
                n_cmp++; if (count2 !== 2'd1) begin n_err++; $display("FAIL stream_steady[%0d] got %0d exp 1", i, count2); end
                n_cmp++; if (m_data2 !== q2[0])
                    begin n_err++; $display("FAIL stream_data[%0d] got %h exp %h", i, m_data2, q2[0]); end
                n_cmp++; if (m_data2 !== 96'(i - 1))
                    begin n_err++; $display("FAIL stream_order[%0d] got %h exp %h", i, m_data2, 96'(i - 1)); end
            end
            tick2();
        end
        drive2(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (m_data2 !== 96'd15) begin n_err++; $display("FAIL stream_last got %h exp f", m_data2); end
        tick2();
        n_cmp++; if (m_valid2 !== 1'b0) begin n_err++; $display("FAIL stream_drain got vld=%b exp 0", m_valid2); end
    endtask

    task automatic test_back_pressure();
        logic [95:0] a = 96'hA0A0_0000_0000_0000_0000_000A;
        logic [95:0] b = 96'hB0B0_0000_0000_0000_0000_000B;
        logic [95:0] d = 96'hD0D0_0000_0000_0000_0000_000D;
        drive2(1'b1, a, 1'b0, 1'b0); tick2();
        drive2(1'b1, b, 1'b0, 1'b0); tick2();
        drive2(1'b1, d, 1'b0, 1'b0);
        n_cmp++; if (count2 !== 2'd2)   begin n_err++; $display("FAIL bp_count got %0d exp 2", count2); end
        n_cmp++; if (s_ready2 !== 1'b0) begin n_err++; $display("FAIL bp_s_ready got %b exp 0", s_ready2); end
        n_cmp++; if (m_data2 !== a)     begin n_err++; $display("FAIL bp_hold got %h exp %h", m_data2, a); end
        tick2();
        n_cmp++; if (m_data2 !== a)     begin n_err++; $display("FAIL bp_hold2 got %h exp %h", m_data2, a); end
        // Full with simultaneous pop: D must not be accepted this cycle.
        drive2(1'b1, d, 1'b1, 1'b0);
        n_cmp++; if (m_data2 !== q2[0]) begin n_err++; $display("FAIL bp_pop got %h exp %h", m_data2, q2[0]); end
        void'(q2.size());
        tick2();
        drive2(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (m_data2 !== b)     begin n_err++; $display("FAIL bp_next got %h exp %h", m_data2, b); end
        n_cmp++; if (s_ready2 !== 1'b1) begin n_err++; $display("FAIL bp_free got %b exp 1", s_ready2); end
        n_cmp++; if (count2 !== 2'(q2.size())) begin n_err++; $display("FAIL bp_cnt got %0d exp %0d", count2, q2.size()); end
        drive2(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (m_data2 !== q2[0]) begin n_err++; $display("FAIL bp_drain got %h exp %h", m_data2, q2[0]); end
        tick2();
        drive2(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (m_valid2 !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b exp 0 (D leaked)", m_valid2); end
    endtask

    task automatic test_flush();
        drive2(1'b1, 96'hE, 1'b0, 1'b0); tick2();
        drive2(1'b1, 96'hF, 1'b0, 1'b0); tick2();
        n_cmp++; if (count2 !== 2'd2) begin n_err++; $display("FAIL flush_pre got %0d exp 2", count2); end
        drive2(1'b1, 96'hC, 1'b1, 1'b1); tick2();
        drive2(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (count2 !== 2'd0)   begin n_err++; $display("FAIL flush_count got %0d exp 0", count2); end
        n_cmp++; if (m_valid2 !== 1'b0) begin n_err++; $display("FAIL flush_m_valid got %b exp 0", m_valid2); end
        n_cmp++; if (s_ready2 !== 1'b1) begin n_err++; $display("FAIL flush_s_ready got %b exp 1", s_ready2); end
        drive2(1'b1, 96'h77, 1'b0, 1'b0); tick2();
        drive2(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (m_valid2 !== 1'b1 || m_data2 !== 96'h77)
            begin n_err++; $display("FAIL flush_after got vld=%b %h exp 1 77", m_valid2, m_data2); end
        tick2();
        drive2(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (m_valid2 !== 1'b0) begin n_err++; $display("FAIL flush_c_leak got vld=%b data=%h exp 0", m_valid2, m_data2); end
    endtask

    task automatic test_wrap_depth3();
        int sent = 0, got = 0, cyc = 0;
        bit push, pop;
        while (got < 10 && cyc < 400) begin
            s_valid3 = (sent < 10) && ($urandom_range(0, 3) != 0);
            s_data3  = 16'h3000 + 16'(sent);
            m_ready3 = ($urandom_range(0, 2) == 0);
            flush3   = 1'b0;
            n_cmp++; if (count3 !== 2'(q3.size()) || s_ready3 !== (q3.size() != 3) || m_valid3 !== (q3.size() != 0))
                begin n_err++; $display("FAIL wrap_state[%0d] got cnt=%0d rdy=%b vld=%b exp cnt=%0d", cyc, count3, s_ready3, m_valid3, q3.size()); end
            push = s_valid3 && (q3.size() != 3);
            pop  = m_ready3 && (q3.size() != 0);
            if (pop) begin
                n_cmp++; if (m_data3 !== q3[0])
                    begin n_err++; $display("FAIL wrap_data[%0d] got %h exp %h", got, m_data3, q3[0]); end
                void'(q3.pop_front());
                got++;
            end
            if (push) begin q3.push_back(s_data3); sent++; end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid3 = 1'b0; m_ready3 = 1'b0;
        n_cmp++; if (got != 10) begin n_err++; $display("FAIL wrap_timeout got %0d delivered exp 10", got); end
    endtask

    task automatic test_reset_mid();
        drive2(1'b1, 96'h51, 1'b0, 1'b0); tick2();
        drive2(1'b1, 96'h52, 1'b0, 1'b0); tick2();
        n_cmp++; if (count2 !== 2'd2 || m_valid2 !== 1'b1)
            begin n_err++; $display("FAIL rmid_pre got cnt=%0d vld=%b exp 2 1", count2, m_valid2); end
        drive2(1'b1, 96'h53, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q2.delete();
        drive2(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (s_ready2 !== 1'b1) begin n_err++; $display("FAIL rmid_s_ready got %b exp 1", s_ready2); end
        n_cmp++; if (m_valid2 !== 1'b0) begin n_err++; $display("FAIL rmid_m_valid got %b exp 0", m_valid2); end
        n_cmp++; if (count2 !== 2'd0)   begin n_err++; $display("FAIL rmid_count got %0d exp 0", count2); end
        n_cmp++; if (m_data2 !== RST2)  begin n_err++; $display("FAIL rmid_m_data got %h exp %h", m_data2, RST2); end
        for (int i = 0; i < 6; i++) begin
            drive2(i < 4, 96'h60 + 96'(i), i > 0, 1'b0);
            if (m_ready2 && q2.size() != 0) begin
                n_cmp++; if (m_data2 !== q2[0])
                    begin n_err++; $display("FAIL rmid_after[%0d] got %h exp %h", i, m_data2, q2[0]); end
            end
            tick2();
        end
        drive2(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (m_valid2 !== 1'b0) begin n_err++; $display("FAIL rmid_drain got vld=%b exp 0", m_valid2); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_wrap_depth3();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
